chan_arbiter: RTL and testbench

//  Reader side of the per-channel block FIFO interface (dout/req/ack). Polls NCH channel

---
 rtl/chan_arbiter_pkg.sv | 15 +
 rtl/chan_arbiter_if.sv | 21 ++
 rtl/chan_arbiter_rr_pick.sv | 21 ++
 rtl/chan_arbiter.sv | 136 +++++++++++++
 tb/tb_chan_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/chan_arbiter_pkg.sv
// chan_arb_pkg: shared FSM states, control-word field helpers and error counter limits
package chan_arb_pkg;
    typedef enum logic [1:0] {IDLE, HDR, GAP, DATA} state_t;
    localparam int CW_FLAG = 15;
    localparam logic [15:0] ERR_MAX = 16'hFFFF;
    function automatic logic [5:0] cw_chan(input logic [15:0] w);
        return w[14:9];
    endfunction
    function automatic logic [8:0] cw_len(input logic [15:0] w);
        return w[8:0];
    endfunction
    function automatic logic [15:0] err_inc(input logic [15:0] c);
        return c == ERR_MAX ? c : c + 16'd1;
    endfunction
endpackage

// File: rtl/chan_arbiter_if.sv
// chan_arbiter_if: channel FIFO read ports plus the forwarded 16-bit word stream
interface chan_arbiter_if #(parameter int NCH = 16);
    logic [16*NCH-1:0] ch_dout;
    logic [NCH-1:0] ch_req;
    logic [NCH-1:0] ch_ack;
    logic [NCH-1:0] chmask;
    logic [15:0] out_data;
    logic out_valid;
    logic out_sob;
    logic out_eob;
    logic out_abort;
    logic out_busy;
    modport master (
        input ch_dout, ch_req, chmask, out_busy,
        output ch_ack, out_data, out_valid, out_sob, out_eob, out_abort
    );
    modport slave (
        output ch_dout, ch_req, chmask, out_busy,
        input ch_ack, out_data, out_valid, out_sob, out_eob, out_abort
    );
endinterface

// File: rtl/chan_arbiter_rr_pick.sv
// rr_pick: round-robin picker, first requesting index after last with wrap-around
module rr_pick #(parameter int NCH = 16) (
    input  logic [NCH-1:0] req,
    input  logic [5:0] last,
    output logic [NCH-1:0] gnt,
    output logic [5:0] idx,
    output logic any
);
    int k;
    always_comb begin
        idx = '0;
        k = 0;
        gnt = '0;
        for (int i = NCH; i > 0; i--) begin
            k = (int'(last) + i) % NCH;
            if (req[k]) idx = 6'(k);
        end
        any = |req;
        for (int i = 0; i < NCH; i++) gnt[i] = any && idx == 6'(i);
    end
endmodule

// File: rtl/chan_arbiter.sv
// chan_arbiter: drains one framed block per round-robin grant into a single 16-bit stream
module chan_arbiter
    import chan_arb_pkg::*;
#(
    parameter int NCH = 16,
    parameter int TOBITS = 8
) (
    input  logic clk,
    input  logic reset,
    chan_arbiter_if.master bus,
    output logic [15:0] err_cnt,
    output logic [5:0] cur_chan
);
    state_t state, state_n;
    logic [8:0] cnt, cnt_n;
    logic [TOBITS-1:0] tmr, tmr_n;
    logic [5:0] last, last_n, cur_n, pick_idx;
    logic [NCH-1:0] gnt_oh, gnt_n, pick_gnt;
    logic pick_any, g_req, ack_en, err_n, v_n, sob_n, eob_n, abort_n;
    logic [15:0] g_word, data_n;

    rr_pick #(.NCH(NCH)) u_pick (
        .req(bus.ch_req & ~bus.chmask),
        .last(last),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

    always_comb begin
        g_word = '0;
        g_req = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (cur_chan == 6'(i)) begin
                g_word = bus.ch_dout[16*i +: 16];
                g_req = bus.ch_req[i];
            end
    end

    // a premature CW in DATA is left unread so the channel presents it again on its next grant
    assign ack_en = state == HDR || (state == DATA && !g_word[CW_FLAG]);
    assign bus.ch_ack = ack_en ? gnt_oh : '0;

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        tmr_n = '0;
        last_n = last;
        cur_n = cur_chan;
        gnt_n = gnt_oh;
        err_n = 1'b0;
        v_n = 1'b0;
        sob_n = 1'b0;
        eob_n = 1'b0;
        abort_n = 1'b0;
        data_n = bus.out_data;
        case (state)
            IDLE:
                if (!bus.out_busy && pick_any) begin
                    cur_n = pick_idx;
                    gnt_n = pick_gnt;
                    state_n = HDR;
                end
            HDR:
                if (g_word[CW_FLAG] && cw_len(g_word) != '0) begin
                    v_n = 1'b1;
                    sob_n = 1'b1;
                    data_n = g_word;
                    cnt_n = cw_len(g_word);
                    err_n = cw_chan(g_word) != cur_chan;
                    state_n = GAP;
                end else begin
                    err_n = 1'b1;
                    state_n = IDLE;
                end
            GAP:
                if (cnt == '0) begin
                    last_n = cur_chan;
                    state_n = IDLE;
                end else if (bus.out_busy || !g_req) begin
                    tmr_n = tmr + TOBITS'(1);
                    if (&tmr) begin
                        abort_n = 1'b1;
                        err_n = 1'b1;
                        tmr_n = '0;
                        state_n = IDLE;
                    end
                end else begin
                    state_n = DATA;
                end
            DATA:
                if (!g_word[CW_FLAG]) begin
                    v_n = 1'b1;
                    data_n = g_word;
                    eob_n = cnt == 9'd1;
                    cnt_n = cnt - 9'd1;
                    state_n = GAP;
                end else begin
                    abort_n = 1'b1;
                    err_n = 1'b1;
                    state_n = IDLE;
                end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            tmr <= '0;
            last <= 6'(NCH - 1);
            cur_chan <= '0;
            gnt_oh <= '0;
            err_cnt <= '0;
            bus.out_data <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sob <= 1'b0;
            bus.out_eob <= 1'b0;
            bus.out_abort <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            tmr <= tmr_n;
            last <= last_n;
            cur_chan <= cur_n;
            gnt_oh <= gnt_n;
            err_cnt <= err_n ? err_inc(err_cnt) : err_cnt;
            bus.out_data <= data_n;
            bus.out_valid <= v_n;
            bus.out_sob <= sob_n;
            bus.out_eob <= eob_n;
            bus.out_abort <= abort_n;
        end
    end
endmodule

// File: tb/tb_chan_arbiter.sv
// tb_chan_arbiter: directed vectors against a per-channel FIFO model with a stream scoreboard
module tb_chan_arbiter;
    localparam int NCH = 16;
    localparam logic [17:0] SOB = 18'h20000;
    localparam logic [17:0] EOB = 18'h10000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] err_cnt;
    logic [5:0] cur_chan;

    chan_arbiter_if #(.NCH(NCH)) bus ();

    chan_arbiter #(.NCH(NCH), .TOBITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .err_cnt(err_cnt),
        .cur_chan(cur_chan)
    );

    always #4 clk = ~clk;

    logic [15:0] mem [NCH][64];
    int wp [NCH];
    int rp [NCH];

    always_comb begin
        bus.ch_dout = '0;
        bus.ch_req = '0;
        for (int k = 0; k < NCH; k++)
            if (rp[k] < wp[k]) begin
                bus.ch_dout[16*k +: 16] = mem[k][rp[k]];
                bus.ch_req[k] = 1'b1;
            end
    end

    always @(posedge clk)
        for (int k = 0; k < NCH; k++)
            if (bus.ch_ack[k] && rp[k] < wp[k]) rp[k] <= rp[k] + 1;

    logic [17:0] obs [$];
    int ack_n [NCH];
    int aborts = 0;
    int ack_b2b = 0;
    int val_b2b = 0;
    logic [NCH-1:0] prev_ack = '0;
    logic prev_val = 1'b0;

    always @(negedge clk) begin
        if (bus.out_valid) obs.push_back({bus.out_sob, bus.out_eob, bus.out_data});
        if (bus.out_abort) aborts <= aborts + 1;
        for (int k = 0; k < NCH; k++)
            if (bus.ch_ack[k]) ack_n[k] <= ack_n[k] + 1;
        if (|(bus.ch_ack & prev_ack)) ack_b2b <= ack_b2b + 1;
        if (bus.out_valid && prev_val) val_b2b <= val_b2b + 1;
        prev_ack <= bus.ch_ack;
        prev_val <= bus.out_valid;
    end

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] w);
        mem[k][wp[k]] = w;
        wp[k]++;
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int c = 0;
        while (obs.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        chk(tag, obs.size(), n);
    endtask

    task automatic chk_word(input string tag, input int i, input logic [17:0] exp);
        chk(tag, i < obs.size() ? 32'(obs[i]) : 32'hFFFF_FFFF, 32'(exp));
    endtask

    task automatic wait_word(input logic [15:0] w, input int budget, output bit found);
        int c = 0;
        found = 1'b0;
        while (!found && c < budget) begin
            @(negedge clk);
            c++;
            found = bus.out_valid && bus.out_data == w;
        end
    endtask

    initial begin
        int base, a, ab, n;
        bit found;
        logic [17:0] e1 [4];
        logic [17:0] e2 [6];
        logic [17:0] e3 [6];
        logic [17:0] e4 [4];
        bus.out_busy = 1'b0;
        bus.chmask = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ack", bus.ch_ack, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_cur", cur_chan, 0);
        chk("rst_outs", {bus.out_sob, bus.out_eob, bus.out_abort, bus.out_data}, 0);
        reset = 1'b0;

        base = obs.size();
        a = ack_n[0];
        push(0, 16'h8003); push(0, 16'h0001); push(0, 16'h0002); push(0, 16'h0003);
        wait_words("t1_cnt", base + 4, 60);
        e1 = '{SOB | 18'h8003, 18'h0001, 18'h0002, EOB | 18'h0003};
        for (int i = 0; i < 4; i++) chk_word($sformatf("t1_w%0d", i), base + i, e1[i]);
        chk("t1_acks", ack_n[0] - a, 4);
        chk("t1_err", err_cnt, 0);

        base = obs.size();
        push(2, 16'h8401); push(2, 16'h0021); push(2, 16'h8401); push(2, 16'h0022);
        push(5, 16'h8A01); push(5, 16'h0051);
        wait_words("t2_cnt", base + 6, 80);
        e2 = '{SOB | 18'h8401, EOB | 18'h0021, SOB | 18'h8A01, EOB | 18'h0051, SOB | 18'h8401, EOB | 18'h0022};
        for (int i = 0; i < 6; i++) chk_word($sformatf("t2_w%0d", i), base + i, e2[i]);

        base = obs.size();
        push(0, 16'h8005);
        for (int i = 1; i <= 5; i++) push(0, 16'(i));
        wait_word(16'h0001, 40, found);
        chk("t3_found", found, 1);
        bus.out_busy = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (|bus.ch_ack || bus.out_valid) n++;
        end
        chk("t3_stall", n, 0);
        bus.out_busy = 1'b0;
        wait_words("t3_cnt", base + 6, 60);
        e3 = '{SOB | 18'h8005, 18'h0001, 18'h0002, 18'h0003, 18'h0004, EOB | 18'h0005};
        for (int i = 0; i < 6; i++) chk_word($sformatf("t3_w%0d", i), base + i, e3[i]);

        base = obs.size();
        a = ack_n[3];
        ab = aborts;
        push(3, 16'h8603); push(3, 16'h0011); push(3, 16'h8601); push(3, 16'h0022);
        wait_words("t4_cnt", base + 4, 60);
        e4 = '{SOB | 18'h8603, 18'h0011, SOB | 18'h8601, EOB | 18'h0022};
        for (int i = 0; i < 4; i++) chk_word($sformatf("t4_w%0d", i), base + i, e4[i]);
        chk("t4_abort", aborts - ab, 1);
        chk("t4_err", err_cnt, 1);
        chk("t4_acks", ack_n[3] - a, 4);

        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        base = obs.size();
        a = ack_n[1];
        ab = aborts;
        push(1, 16'h0123); push(1, 16'h8202); push(1, 16'h0001);
        wait_word(16'h0001, 40, found);
        chk("t5_found", found, 1);
        chk("t5_err_drop", err_cnt, 1);
        n = 0;
        while (!bus.out_abort && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t5_timeout", n, 256);
        @(negedge clk);
        chk("t5_err_tmo", err_cnt, 2);
        chk("t5_abort", aborts - ab, 1);
        chk("t5_acks", ack_n[1] - a, 3);
        chk("t5_cnt", obs.size(), base + 2);
        chk_word("t5_w0", base, SOB | 18'h8202);
        chk_word("t5_w1", base + 1, 18'h0001);

        base = obs.size();
        push(1, 16'h8201); push(1, 16'h0011);
        wait_words("t6_pre", base + 2, 40);
        push(4, 16'h8803); push(4, 16'h0042); push(4, 16'h0043); push(4, 16'h0044);
        found = 1'b0;
        n = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            found = bus.ch_ack[4] && !bus.ch_dout[79];
        end
        chk("t6_in_data", found, 1);
        reset = 1'b1;
        #1;
        chk("t6_ack", bus.ch_ack, 0);
        chk("t6_outs", {bus.out_valid, bus.out_sob, bus.out_eob, bus.out_abort, bus.out_data}, 0);
        chk("t6_err", err_cnt, 0);
        chk("t6_cur", cur_chan, 0);
        push(0, 16'h8001); push(0, 16'h0007);
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        base = obs.size();
        n = 0;
        while (!(|bus.ch_ack) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_ack", bus.ch_ack, 16'h0001);
        chk("t6_first_cur", cur_chan, 0);
        wait_words("t6_cnt", base + 2, 40);
        chk_word("t6_w0", base, SOB | 18'h8001);
        chk_word("t6_w1", base + 1, EOB | 18'h0007);

        repeat (20) @(negedge clk);
        bus.chmask[6] = 1'b1;
        base = obs.size();
        a = ack_n[6];
        push(6, 16'h8C01); push(6, 16'h0061);
        repeat (30) @(negedge clk);
        chk("t7_masked", ack_n[6] - a, 0);
        bus.chmask[6] = 1'b0;
        wait_words("t7_cnt", base + 2, 40);
        chk_word("t7_w0", base, SOB | 18'h8C01);
        chk_word("t7_w1", base + 1, EOB | 18'h0061);

        chk("ack_spacing", ack_b2b, 0);
        chk("valid_spacing", val_b2b, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
